// File: rtl/reg_dump_pkg.sv
// Shared types and default widths for the register-dump streamer.
// Imported by the reader core and its stream interface.
package reg_dump_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready word stream leaving the register-dump reader.
// master = reader side, slave = downstream consumer.
interface reg_dump_reader_if
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              last;

  modport master (
    output valid,
    output data,
    output addr,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  addr,
    input  last,
    output ready
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks a register index range (with wrap) and streams each word
// as a snapshot over a valid/ready handshake.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic [ADDR_W-1:0] iFirst,
  input  logic [ADDR_W-1:0] iLast,
  output logic [ADDR_W-1:0] oRaddr,
  input  logic [DATA_W-1:0] iRdata,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oLast,
  output logic              oBusy,
  output logic              oDone
);

  state_t            r_state;
  state_t            w_state_n;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_n;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] w_end_n;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_n;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_n;
  logic              r_last;
  logic              w_last_n;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_end   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_end   <= w_end_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_last  <= w_last_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_end_n   = r_end;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_last_n  = r_last;
    unique case (r_state)
      IDLE: begin
        if (iStart) begin
          w_ptr_n   = iFirst;
          w_end_n   = iLast;
          w_state_n = FETCH;
        end
      end
      FETCH: begin
        if (iAbort) begin
          w_state_n = IDLE;
        end else begin
          w_data_n  = iRdata;
          w_addr_n  = r_ptr;
          w_last_n  = (r_ptr == r_end);
          w_state_n = SEND;
        end
      end
      SEND: begin
        // abort wins over a handshake in the same cycle
        if (iAbort) begin
          w_state_n = IDLE;
        end else if (iReady) begin
          if (r_last) begin
            w_state_n = DONE;
          end else begin
            w_ptr_n   = ADDR_W'(r_ptr + 1'b1);
            w_state_n = FETCH;
          end
        end
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign oRaddr = r_ptr;
  assign oData  = r_data;
  assign oAddr  = r_addr;
  assign oLast  = r_last;
  assign oValid = (r_state == SEND);
  assign oBusy  = (r_state != IDLE);
  assign oDone  = (r_state == DONE);

endmodule
